// File: rtl/sequence_transmitter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sequence_transmitter_pkg                                             |
// | Shared state encoding and default pattern for transmitter/detector.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sequence_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int                     DEFAULT_LEN     = 12;
    localparam logic [DEFAULT_LEN-1:0] DEFAULT_PATTERN = 12'b1110_1101_1011;

endpackage
`default_nettype wire

// File: rtl/sequence_transmitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sequence_transmitter_if                                              |
// | Request handshake plus serial output bundle.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sequence_transmitter_if
    import sequence_transmitter_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN,
    parameter int RW  = 4
);
    logic           pat_valid_i;
    logic [LEN-1:0] pat_i;
    logic [RW-1:0]  rep_i;
    logic           abort_i;
    logic           pat_ready_o;
    logic           tx_o;
    logic           tx_en_o;
    logic           sof_o;
    logic           done_o;

    modport master (
        output pat_valid_i, pat_i, rep_i, abort_i,
        input  pat_ready_o, tx_o, tx_en_o, sof_o, done_o
    );

    modport slave (
        input  pat_valid_i, pat_i, rep_i, abort_i,
        output pat_ready_o, tx_o, tx_en_o, sof_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_serializer                                                       |
// | MSB-first shift register with wrapping bit counter and last-bit flag.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_serializer #(
    parameter int LEN = 12
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     clear,
    input  wire logic                     load,
    input  wire logic                     shift,
    input  wire logic [LEN-1:0]           load_data,
    output logic                          bit_out,
    output logic [$clog2(LEN)-1:0]        bit_idx,
    output logic                          last_bit
);
    localparam int IW = $clog2(LEN);

    logic [LEN-1:0] shreg;

    // Shifting zeros in means the register is empty once the last bit leaves,
    // so bit_out is already 0 between frames without extra gating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_idx <= '0;
        end else if (shift) begin
            shreg   <= {shreg[LEN-2:0], 1'b0};
            bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
        end
    end

    assign bit_out  = shreg[LEN-1];
    assign last_bit = (bit_idx == IW'(LEN-1));

endmodule
`default_nettype wire

// File: rtl/sequence_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sequence_transmitter                                                 |
// | Serializes a captured pattern rep_i+1 times with optional idle gaps. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sequence_transmitter
    import sequence_transmitter_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN,
    parameter int GAP = 0,
    parameter int RW  = 4
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    sequence_transmitter_if.slave   bus
);
    localparam int IW = $clog2(LEN);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t         state;
    state_t         next_state;
    logic [LEN-1:0] pat_q;
    logic [RW-1:0]  rep_cnt;
    logic [GW-1:0]  gap_cnt;

    logic           accept;
    logic           more_frames;
    logic           gap_done;
    logic           load;
    logic           shift;
    logic           clear;
    logic [LEN-1:0] load_data;

    logic           tx_bit;
    logic [IW-1:0]  bit_idx;
    logic           last_bit;

    logic           tx_en_q, sof_q, done_q, ready_q;
    logic           tx_en_d, sof_d, done_d, ready_d;

    assign accept      = (state == ST_IDLE) && bus.pat_valid_i;
    assign more_frames = (rep_cnt != '0);
    assign gap_done    = (int'(gap_cnt) == GAP - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_SEND;
            end
            ST_SEND: begin
                if (bus.abort_i) begin
                    next_state = ST_IDLE;
                end else if (last_bit) begin
                    if (!more_frames)  next_state = ST_IDLE;
                    else if (GAP > 0)  next_state = ST_GAP;
                    else               next_state = ST_SEND;
                end
            end
            ST_GAP: begin
                if (bus.abort_i)   next_state = ST_IDLE;
                else if (gap_done) next_state = ST_SEND;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so a load at the
    // accepting edge makes bit 0 and sof visible in the following cycle.
    always_comb begin
        clear     = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        load_data = pat_q;
        case (state)
            ST_IDLE: begin
                load      = accept;
                load_data = bus.pat_i;
            end
            ST_SEND: begin
                if (bus.abort_i)                                clear = 1'b1;
                else if (last_bit && more_frames && (GAP == 0)) load  = 1'b1;
                else                                            shift = 1'b1;
            end
            ST_GAP: begin
                if (bus.abort_i)   clear = 1'b1;
                else if (gap_done) load  = 1'b1;
            end
            default: ;
        endcase
        tx_en_d = (next_state == ST_SEND);
        sof_d   = load;
        done_d  = shift && (bit_idx == IW'(LEN-2)) && !more_frames;
        ready_d = (next_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                pat_q   <= bus.pat_i;
                rep_cnt <= bus.rep_i;
            end else if (load) begin
                rep_cnt <= rep_cnt - 1'b1;
            end else if (clear) begin
                rep_cnt <= '0;
            end
            gap_cnt <= ((state == ST_GAP) && (next_state == ST_GAP)) ? gap_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_en_q <= 1'b0;
            sof_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            tx_en_q <= tx_en_d;
            sof_q   <= sof_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    seq_serializer #(
        .LEN (LEN)
    ) u_serializer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (load),
        .shift     (shift),
        .load_data (load_data),
        .bit_out   (tx_bit),
        .bit_idx   (bit_idx),
        .last_bit  (last_bit)
    );

    assign bus.pat_ready_o = ready_q;
    assign bus.tx_o        = tx_bit;
    assign bus.tx_en_o     = tx_en_q;
    assign bus.sof_o       = sof_q;
    assign bus.done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sequence_transmitter                                              |
// | Directed bench: GAP=0 and GAP=3 instances with looped-back detectors.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sequence_transmitter;
    import sequence_transmitter_pkg::*;

    localparam int LEN = DEFAULT_LEN;
    localparam int RW  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    sequence_transmitter_if #(.LEN(LEN), .RW(RW)) bus0 ();
    sequence_transmitter_if #(.LEN(LEN), .RW(RW)) bus3 ();

    sequence_transmitter #(.LEN(LEN), .GAP(0), .RW(RW)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    sequence_transmitter #(.LEN(LEN), .GAP(3), .RW(RW)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Looped-back detectors: count full pattern matches within contiguous tx_en runs
    logic [LEN-1:0] hist0 = '0;
    logic [LEN-1:0] hist3 = '0;
    int run0 = 0, run3 = 0, fires0 = 0, fires3 = 0;

    always @(posedge clk) begin
        if (bus0.tx_en_o) begin
            hist0 <= {hist0[LEN-2:0], bus0.tx_o};
            run0  <= run0 + 1;
            if (({hist0[LEN-2:0], bus0.tx_o} == DEFAULT_PATTERN) && (run0 >= LEN-1))
                fires0 <= fires0 + 1;
        end else begin
            run0 <= 0;
        end
    end

    always @(posedge clk) begin
        if (bus3.tx_en_o) begin
            hist3 <= {hist3[LEN-2:0], bus3.tx_o};
            run3  <= run3 + 1;
            if (({hist3[LEN-2:0], bus3.tx_o} == DEFAULT_PATTERN) && (run3 >= LEN-1))
                fires3 <= fires3 + 1;
        end else begin
            run3 <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample n cycles starting with the current one (index 1) into bit masks
    task automatic observe(input bit sel, input int n, output logic [63:0] en_m,
                           output logic [63:0] sof_m, output logic [63:0] done_m,
                           output int leak);
        en_m = '0; sof_m = '0; done_m = '0; leak = 0;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) tick();
            if (sel ? bus3.tx_en_o : bus0.tx_en_o) en_m[i]   = 1'b1;
            if (sel ? bus3.sof_o   : bus0.sof_o)   sof_m[i]  = 1'b1;
            if (sel ? bus3.done_o  : bus0.done_o)  done_m[i] = 1'b1;
            if (sel ? (bus3.tx_o && !bus3.tx_en_o) : (bus0.tx_o && !bus0.tx_en_o)) leak++;
        end
    endtask

    // Single frame on dut0 with every bit, sof, done and ready checked
    task automatic send_frame_check(input logic [LEN-1:0] pat, input logic abort_at_accept);
        bus0.pat_i       = pat;
        bus0.rep_i       = '0;
        bus0.abort_i     = abort_at_accept;
        bus0.pat_valid_i = 1'b1;
        tick();
        bus0.pat_valid_i = 1'b0;
        bus0.abort_i     = 1'b0;
        check("frm_sof", bus0.sof_o, 1'b1);
        check("frm_busy", bus0.pat_ready_o, 1'b0);
        for (int k = 0; k < LEN; k++) begin
            if (k > 0) tick();
            check("frm_bit", bus0.tx_o, pat[LEN-1-k]);
            check("frm_en", bus0.tx_en_o, 1'b1);
        end
        check("frm_done", bus0.done_o, 1'b1);
        tick();
        check("frm_ready", bus0.pat_ready_o, 1'b1);
        check("frm_done_end", bus0.done_o, 1'b0);
        check("frm_en_end", bus0.tx_en_o, 1'b0);
    endtask

    logic [63:0]    en_m, sof_m, done_m;
    int             leak, f0, f3;
    logic [LEN-1:0] pat_a, pat_b;

    initial begin
        bus0.pat_valid_i = 1'b0; bus0.pat_i = '0; bus0.rep_i = '0; bus0.abort_i = 1'b0;
        bus3.pat_valid_i = 1'b0; bus3.pat_i = '0; bus3.rep_i = '0; bus3.abort_i = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus0.pat_ready_o, 1'b1);
        check("rst_en", bus0.tx_en_o, 1'b0);
        check("rst_tx", bus0.tx_o, 1'b0);
        check("rst_sof", bus0.sof_o, 1'b0);
        check("rst_done", bus0.done_o, 1'b0);
        check("rst_ready3", bus3.pat_ready_o, 1'b1);
        reset_n = 1'b1;
        observe(1'b0, 4, en_m, sof_m, done_m, leak);
        check("post_rst_idle", en_m, 64'h0);

        // Default pattern, single frame
        f0 = fires0;
        send_frame_check(DEFAULT_PATTERN, 1'b0);
        check("det_once", 64'(fires0 - f0), 64'd1);

        // Two back-to-back frames with GAP=0
        bus0.pat_i = DEFAULT_PATTERN; bus0.rep_i = 4'd1; bus0.pat_valid_i = 1'b1;
        tick();
        bus0.pat_valid_i = 1'b0;
        observe(1'b0, 28, en_m, sof_m, done_m, leak);
        check("b2b_en", en_m, 64'h1FF_FFFE);
        check("b2b_sof", sof_m, (64'h1 << 1) | (64'h1 << 13));
        check("b2b_done", done_m, 64'h1 << 24);
        check("b2b_leak", 64'(leak), 64'd0);
        check("b2b_ready", bus0.pat_ready_o, 1'b1);

        // Three frames separated by 3 idle cycles on the GAP=3 instance
        f3 = fires3;
        bus3.pat_i = DEFAULT_PATTERN; bus3.rep_i = 4'd2; bus3.pat_valid_i = 1'b1;
        tick();
        bus3.pat_valid_i = 1'b0;
        observe(1'b1, 45, en_m, sof_m, done_m, leak);
        check("gap_en", en_m, (64'hFFF << 1) | (64'hFFF << 16) | (64'hFFF << 31));
        check("gap_sof", sof_m, (64'h1 << 1) | (64'h1 << 16) | (64'h1 << 31));
        check("gap_done", done_m, 64'h1 << 42);
        check("gap_leak", 64'(leak), 64'd0);
        check("gap_det", 64'(fires3 - f3), 64'd3);
        check("gap_ready", bus3.pat_ready_o, 1'b1);

        // Abort during bit 5, then a clean restart (abort in IDLE is ignored)
        bus0.pat_i = DEFAULT_PATTERN; bus0.rep_i = 4'd0; bus0.pat_valid_i = 1'b1;
        tick();
        bus0.pat_valid_i = 1'b0;
        repeat (5) tick();
        check("abt_bit5", bus0.tx_o, 1'b1);
        bus0.abort_i = 1'b1;
        tick();
        bus0.abort_i = 1'b0;
        check("abt_en", bus0.tx_en_o, 1'b0);
        check("abt_sof", bus0.sof_o, 1'b0);
        check("abt_tx", bus0.tx_o, 1'b0);
        check("abt_ready", bus0.pat_ready_o, 1'b1);
        observe(1'b0, 8, en_m, sof_m, done_m, leak);
        check("abt_no_done", done_m, 64'h0);
        check("abt_quiet", en_m, 64'h0);
        send_frame_check(12'b1010_0110_0101, 1'b1);

        // Held request with pattern changed mid-frame
        pat_a = 12'b1100_1010_0111;
        pat_b = 12'b0011_0101_1001;
        bus0.pat_i = pat_a; bus0.rep_i = 4'd0; bus0.pat_valid_i = 1'b1;
        tick();
        bus0.pat_i = pat_b;
        for (int k = 0; k < LEN; k++) begin
            if (k > 0) tick();
            check("hold_bit_a", bus0.tx_o, pat_a[LEN-1-k]);
        end
        check("hold_done_a", bus0.done_o, 1'b1);
        tick();
        check("hold_ready", bus0.pat_ready_o, 1'b1);
        check("hold_gapless", bus0.tx_en_o, 1'b0);
        tick();
        bus0.pat_valid_i = 1'b0;
        check("hold_sof_b", bus0.sof_o, 1'b1);
        for (int k = 0; k < LEN; k++) begin
            if (k > 0) tick();
            check("hold_bit_b", bus0.tx_o, pat_b[LEN-1-k]);
        end
        check("hold_done_b", bus0.done_o, 1'b1);
        tick();

        // Asynchronous reset mid-frame
        bus0.pat_i = DEFAULT_PATTERN; bus0.rep_i = 4'd3; bus0.pat_valid_i = 1'b1;
        tick();
        bus0.pat_valid_i = 1'b0;
        repeat (3) tick();
        check("arst_pre_en", bus0.tx_en_o, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        check("arst_en", bus0.tx_en_o, 1'b0);
        check("arst_tx", bus0.tx_o, 1'b0);
        check("arst_sof", bus0.sof_o, 1'b0);
        check("arst_done", bus0.done_o, 1'b0);
        check("arst_ready", bus0.pat_ready_o, 1'b1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        observe(1'b0, 20, en_m, sof_m, done_m, leak);
        check("arst_no_resume", en_m, 64'h0);
        check("arst_ready_hold", bus0.pat_ready_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sequence_transmitter.md
SEQUENCE_TRANSMITTER -- requirements
Module: sequence_transmitter

Interface
REQ-001 Parameter LEN, default 12: pattern length in bits, minimum 2.
REQ-002 Parameter GAP, default 0: idle cycles inserted between repetitions of one request.
REQ-003 Parameter RW, default 4: width of the repeat-count field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pat_valid_i  input  1  request valid; pat_i and rep_i are stable while it is high.
REQ-007 pat_i  input  LEN  pattern to serialize; MSB is sent first.
REQ-008 rep_i  input  RW  repetitions minus one: rep_i+1 frames are sent.
REQ-009 abort_i  input  1  synchronous abort of the request in progress.
REQ-010 pat_ready_o  output  1  ready to accept a request.
REQ-011 tx_o  output  1  serial data bit.
REQ-012 tx_en_o  output  1  tx_o carries a pattern bit this cycle.
REQ-013 sof_o  output  1  first bit of each frame.
REQ-014 done_o  output  1  one-cycle pulse on the last bit of the final frame.

Function
REQ-015 States SHALL be IDLE, SEND and GAP; pat_ready_o SHALL be high only in IDLE.
REQ-016 A request SHALL be accepted at a rising edge where pat_valid_i and pat_ready_o are both high; pat_i and rep_i SHALL be captured into internal registers at that edge.
REQ-017 Changes to pat_i or rep_i after acceptance SHALL have no effect on the request in progress.
REQ-018 Latency: for acceptance at edge N, bit pat_i[LEN-1] SHALL appear on tx_o during cycle N+1; bit k of the frame SHALL appear in cycle N+1+k.
REQ-019 All outputs SHALL be registered.
REQ-020 Outside frame bits, tx_en_o SHALL be 0 and tx_o SHALL be 0.
REQ-021 sof_o SHALL equal tx_en_o AND (bit index == 0).
REQ-022 IDLE -> SEND on acceptance.
REQ-023 SEND -> GAP after the last bit when repetitions remain and GAP > 0.
REQ-024 SEND -> SEND (next frame back-to-back, bit index wraps to 0) after the last bit when repetitions remain and GAP == 0.
REQ-025 SEND -> IDLE after the last bit of the final frame, with done_o high during that last bit.
REQ-026 GAP -> SEND after exactly GAP cycles.
REQ-027 The bit counter SHALL be $clog2(LEN) bits and wrap from LEN-1 to 0.
REQ-028 The repeat counter SHALL be RW bits and count down to 0 without underflow.
REQ-029 rep_i at its maximum (all ones) SHALL yield 2^RW frames.
REQ-030 abort_i high at an edge in SEND or GAP SHALL force IDLE at that edge, with no done_o, and with tx_en_o and sof_o low in the next cycle.
REQ-031 abort_i SHALL take priority over frame completion.
REQ-032 abort_i in IDLE SHALL be ignored, and acceptance in the same cycle SHALL proceed normally.
REQ-033 pat_valid_i high while not in IDLE SHALL be held off, not dropped; it is accepted at the first edge in IDLE.
REQ-034 pat_ready_o SHALL rise in the cycle after done_o.

Reset
REQ-035 reset_n low SHALL immediately force the following, regardless of the current state:
- state = IDLE
- pat_ready_o = 1
- tx_o, tx_en_o, sof_o, done_o = 0
- all counters and pattern registers = 0
REQ-036 Reset deassertion SHALL not start transmission; a new handshake is required.

Structure
REQ-037 A shared package SHALL hold:
- the state enum (IDLE, SEND, GAP)
- the default pattern constant 12'b1110_1101_1011
- the default LEN of 12
This keeps transmitter and detector benches consistent.
REQ-038 The shift/bit-count datapath SHALL be one sub-module, seq_serializer (load, shift, last-bit flag); the FSM and repeat/gap counters SHALL stay in sequence_transmitter.

Verification
REQ-039 Default pattern, rep_i=0, accepted at edge N -> bench SHALL check:
- tx_o = 1,1,1,0,1,1,0,1,1,0,1,1 in cycles N+1..N+12
- sof_o high at N+1
- done_o high at N+12
- pat_ready_o high at N+13
- a looped-back sequence detector fires exactly once
REQ-040 rep_i=2, GAP=3 -> three frames separated by exactly 3 cycles with tx_en_o low; sof_o pulses 3 times; done_o pulses once; the detector fires 3 times.
REQ-041 rep_i=1, GAP=0 -> 24 contiguous tx_en_o cycles; sof_o in cycles N+1 and N+13.
REQ-042 abort_i asserted during bit 5 of a frame -> IDLE next cycle; tx_en_o low; no done_o; a following request starts cleanly from bit 0.
REQ-043 reset_n pulsed low mid-frame, asynchronously to clk -> outputs reach reset values immediately; no transmission resumes after release.
REQ-044 pat_valid_i held high and pat_i changed during a frame -> the in-flight frame is unchanged; the new pattern is accepted at the first IDLE edge.
